// File: rtl/ift_sram_copier_pkg.sv
// Shared types and helpers for the taint-tracking SRAM copy engine.
package ift_sram_copier_pkg;

    // Engine states: one read, a fixed read-latency wait, one write per word.
    typedef enum logic [2:0] {
        IDLE,
        RD,
        LAT,
        WR,
        DONE
    } copier_state_e;

    // Integer ceiling division, used to size the byte-enable vector.
    function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ift_sram_copier.sv
// Taint-tracking memory-to-memory copy engine; sole initiator of a single-port SRAM.
module ift_sram_copier
    import ift_sram_copier_pkg::*;
#(
    parameter  int unsigned NumWords   = 1024,
    parameter  int unsigned DataWidth  = 128,
    parameter  int unsigned ByteWidth  = 8,
    parameter  int unsigned Latency    = 1,
    parameter  int unsigned NumTaints  = 1,
    localparam int unsigned AddrWidth  = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int unsigned WidthBytes = ceil_div(DataWidth, ByteWidth)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   start_i,
    input  logic [NumTaints-1:0][0:0]              start_i_t0,
    input  logic [AddrWidth-1:0]                   src_addr_i,
    input  logic [NumTaints-1:0][AddrWidth-1:0]    src_addr_i_t0,
    input  logic [AddrWidth-1:0]                   dst_addr_i,
    input  logic [NumTaints-1:0][AddrWidth-1:0]    dst_addr_i_t0,
    input  logic [AddrWidth:0]                     len_i,
    input  logic [NumTaints-1:0][AddrWidth:0]      len_i_t0,
    output logic                                   busy_o,
    output logic [NumTaints-1:0][0:0]              busy_o_t0,
    output logic                                   done_o,
    output logic [NumTaints-1:0][0:0]              done_o_t0,
    output logic                                   req_o,
    output logic [NumTaints-1:0][0:0]              req_o_t0,
    output logic                                   we_o,
    output logic [NumTaints-1:0][0:0]              we_o_t0,
    output logic [AddrWidth-1:0]                   addr_o,
    output logic [NumTaints-1:0][AddrWidth-1:0]    addr_o_t0,
    output logic [DataWidth-1:0]                   wdata_o,
    output logic [NumTaints-1:0][DataWidth-1:0]    wdata_o_t0,
    output logic [WidthBytes-1:0]                  be_o,
    output logic [NumTaints-1:0][WidthBytes-1:0]   be_o_t0,
    input  logic [DataWidth-1:0]                   rdata_i,
    input  logic [NumTaints-1:0][DataWidth-1:0]    rdata_i_t0
);

    localparam int unsigned LatCntW = (Latency > 1) ? $clog2(Latency) : 1;

    copier_state_e        state_q, state_d;
    logic [AddrWidth-1:0] src_q, dst_q;
    logic [AddrWidth:0]   len_q, idx_q, idx_inc;
    logic [LatCntW-1:0]   lat_q;
    logic                 lat_last;
    logic [DataWidth-1:0] data_q, data_t_q;
    logic                 src_t_q, dst_t_q, ctrl_t_q;

    assign idx_inc  = idx_q + (AddrWidth + 1)'(1);
    assign lat_last = (lat_q == LatCntW'(Latency - 1));

    // State register plus command latch, latency counter and read-data capture.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            lat_q    <= '0;
            // NOTE: the word buffer is reset too, so no X can ever leak onto wdata_o_t0.
            data_q   <= '0;
            data_t_q <= '0;
            src_t_q  <= 1'b0;
            dst_t_q  <= 1'b0;
            ctrl_t_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register sees pre-edge values.
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        src_q    <= src_addr_i;
                        dst_q    <= dst_addr_i;
                        len_q    <= len_i;
                        idx_q    <= '0;
                        lat_q    <= '0;
                        src_t_q  <= |src_addr_i_t0[0];
                        dst_t_q  <= |dst_addr_i_t0[0];
                        ctrl_t_q <= start_i_t0[0][0] | (|len_i_t0[0]);
                    end
                end
                LAT: begin
                    if (lat_last) begin
                        lat_q    <= '0;
                        data_q   <= rdata_i;
                        data_t_q <= rdata_i_t0[0];
                    end else begin
                        lat_q <= lat_q + LatCntW'(1);
                    end
                end
                WR: idx_q <= idx_inc;
                DONE: begin
                    src_t_q  <= 1'b0;
                    dst_t_q  <= 1'b0;
                    ctrl_t_q <= 1'b0;
                    data_t_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic and SRAM/requester outputs, including taint shadows.
    always_comb begin
        // NOTE: everything gets a default first, so no path can infer a latch.
        state_d    = state_q;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        req_o      = 1'b0;
        we_o       = 1'b0;
        addr_o     = '0;
        wdata_o    = '0;
        be_o       = '0;
        busy_o_t0  = '0;
        done_o_t0  = '0;
        req_o_t0   = '0;
        we_o_t0    = '0;
        addr_o_t0  = '0;
        wdata_o_t0 = '0;
        be_o_t0    = '0;

        if (state_q != IDLE) begin
            busy_o           = 1'b1;
            busy_o_t0[0][0]  = ctrl_t_q;
            done_o_t0[0][0]  = ctrl_t_q;
            req_o_t0[0][0]   = ctrl_t_q;
            we_o_t0[0][0]    = ctrl_t_q;
            be_o_t0[0]       = {WidthBytes{ctrl_t_q}};
            addr_o_t0[0]     = {AddrWidth{ctrl_t_q}};
            wdata_o_t0[0]    = {DataWidth{ctrl_t_q}};
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? DONE : RD;
                end
            end
            RD: begin
                req_o   = 1'b1;
                be_o    = '1;
                addr_o  = src_q + idx_q[AddrWidth-1:0];
                // Any tainted base bit can ripple through the carry chain.
                addr_o_t0[0] = {AddrWidth{ctrl_t_q | src_t_q}};
                state_d = LAT;
            end
            LAT: begin
                if (lat_last) begin
                    state_d = WR;
                end
            end
            WR: begin
                req_o         = 1'b1;
                we_o          = 1'b1;
                be_o          = '1;
                addr_o        = dst_q + idx_q[AddrWidth-1:0];
                wdata_o       = data_q;
                addr_o_t0[0]  = {AddrWidth{ctrl_t_q | dst_t_q}};
                wdata_o_t0[0] = data_t_q | {DataWidth{ctrl_t_q}};
                state_d       = (idx_inc == len_q) ? DONE : RD;
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ift_sram_copier.sv
// Self-checking bench for ift_sram_copier with a behavioural taint-aware SRAM responder.
module tb_ift_sram_copier;

    localparam int NW = 1024;
    localparam int DW = 128;
    localparam int AW = 10;
    localparam int NB = 16;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;

    logic                 start_i;
    logic [0:0][0:0]      start_i_t0;
    logic [AW-1:0]        src_addr_i, dst_addr_i;
    logic [0:0][AW-1:0]   src_addr_i_t0, dst_addr_i_t0;
    logic [AW:0]          len_i;
    logic [0:0][AW:0]     len_i_t0;
    logic                 busy_o, done_o, req_o, we_o;
    logic [0:0][0:0]      busy_o_t0, done_o_t0, req_o_t0, we_o_t0;
    logic [AW-1:0]        addr_o;
    logic [0:0][AW-1:0]   addr_o_t0;
    logic [DW-1:0]        wdata_o;
    logic [0:0][DW-1:0]   wdata_o_t0;
    logic [NB-1:0]        be_o;
    logic [0:0][NB-1:0]   be_o_t0;
    logic [DW-1:0]        rdata_s;
    logic [0:0][DW-1:0]   rdata_t0_s;

    ift_sram_copier #(
        .NumWords (NW),
        .DataWidth(DW),
        .ByteWidth(8),
        .Latency  (1),
        .NumTaints(1)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .start_i_t0   (start_i_t0),
        .src_addr_i   (src_addr_i),
        .src_addr_i_t0(src_addr_i_t0),
        .dst_addr_i   (dst_addr_i),
        .dst_addr_i_t0(dst_addr_i_t0),
        .len_i        (len_i),
        .len_i_t0     (len_i_t0),
        .busy_o       (busy_o),
        .busy_o_t0    (busy_o_t0),
        .done_o       (done_o),
        .done_o_t0    (done_o_t0),
        .req_o        (req_o),
        .req_o_t0     (req_o_t0),
        .we_o         (we_o),
        .we_o_t0      (we_o_t0),
        .addr_o       (addr_o),
        .addr_o_t0    (addr_o_t0),
        .wdata_o      (wdata_o),
        .wdata_o_t0   (wdata_o_t0),
        .be_o         (be_o),
        .be_o_t0      (be_o_t0),
        .rdata_i      (rdata_s),
        .rdata_i_t0   (rdata_t0_s)
    );

    always #5 clk_i = ~clk_i;

    int cyc;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Responder SRAM (latency 1) with a backdoor write port for preloading.
    logic [DW-1:0] mem  [NW];
    logic [DW-1:0] memt [NW];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data, bd_t;

    always @(posedge clk_i) begin
        if (bd_we) begin
            mem[bd_addr]  <= bd_data;
            memt[bd_addr] <= bd_t;
        end else if (req_o) begin
            if (we_o) begin
                mem[addr_o]  <= wdata_o;
                memt[addr_o] <= wdata_o_t0[0] | {DW{(|addr_o_t0[0]) | req_o_t0[0][0] | we_o_t0[0][0]}};
            end else begin
                rdata_s       <= mem[addr_o];
                rdata_t0_s[0] <= memt[addr_o] | {DW{(|addr_o_t0[0]) | req_o_t0[0][0]}};
            end
        end
    end

    // Reference memory image maintained by the bench.
    logic [DW-1:0] ref_mem [NW];
    logic [DW-1:0] ref_t   [NW];

    int n_cmp = 0;
    int n_bad = 0;

    // Observations gathered by run_copy.
    int            rd_cyc[$], wr_cyc[$], done_cyc[$];
    logic [AW-1:0] rd_addr[$], wr_addr[$], rd_at[$], wr_at[$];
    int            busy_bad, be_bad, t0_nz, ctrl_ones, busy_cycles, rd_seq_bad, wr_seq_bad;
    logic          abort_req, abort_busy;

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] t);
        bd_we = 1'b1; bd_addr = a; bd_data = d; bd_t = t;
        ref_mem[a] = d; ref_t[a] = t;
        @(negedge clk_i);
        bd_we = 1'b0;
    endtask

    // Copy semantics: ascending word order, destination fully tainted if any control/address taint.
    task automatic model_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n, input bit tainted);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] s, d;
            s = src + AW'(k);
            d = dst + AW'(k);
            ref_mem[d] = ref_mem[s];
            ref_t[d]   = tainted ? '1 : ref_t[s];
        end
    endtask

    function automatic int mem_diff();
        int n = 0;
        for (int i = 0; i < NW; i++)
            if (mem[i] !== ref_mem[i] || memt[i] !== ref_t[i]) n++;
        return n;
    endfunction

    task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW:0] len,
                            input logic st_t, input logic [AW-1:0] src_t, input logic [AW-1:0] dst_t,
                            input logic [AW:0] len_t, input int abort_at, input bit noise);
        int c0, c, exp_done;
        exp_done = (len == 0) ? 1 : int'(len) * 3 + 1;
        rd_cyc.delete(); wr_cyc.delete(); done_cyc.delete();
        rd_addr.delete(); wr_addr.delete(); rd_at.delete(); wr_at.delete();
        busy_bad = 0; be_bad = 0; t0_nz = 0; ctrl_ones = 0; busy_cycles = 0;
        abort_req = 1'bx; abort_busy = 1'bx;
        @(negedge clk_i);
        start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = len;
        start_i_t0[0][0] = st_t; src_addr_i_t0[0] = src_t; dst_addr_i_t0[0] = dst_t; len_i_t0[0] = len_t;
        c0 = cyc;
        for (int i = 0; i < exp_done + 2; i++) begin
            @(negedge clk_i);
            c = cyc - c0;
            if (busy_o !== ((c >= 1 && c <= exp_done) ? 1'b1 : 1'b0)) busy_bad++;
            if (busy_o) busy_cycles++;
            if (busy_o && req_o_t0[0][0] && done_o_t0[0][0] && busy_o_t0[0][0] && we_o_t0[0][0] && (&be_o_t0[0]))
                ctrl_ones++;
            if ((busy_o_t0 | done_o_t0 | req_o_t0 | we_o_t0) != '0 || be_o_t0 != '0 || addr_o_t0 != '0 || wdata_o_t0 != '0)
                t0_nz++;
            if (req_o) begin
                if (be_o !== '1) be_bad++;
                if (we_o) begin
                    wr_cyc.push_back(c); wr_addr.push_back(addr_o); wr_at.push_back(addr_o_t0[0]);
                end else begin
                    rd_cyc.push_back(c); rd_addr.push_back(addr_o); rd_at.push_back(addr_o_t0[0]);
                end
            end else if (be_o !== '0 || we_o !== 1'b0) begin
                be_bad++;
            end
            if (done_o) done_cyc.push_back(c);
            start_i = 1'b0; start_i_t0 = '0; src_addr_i_t0 = '0; dst_addr_i_t0 = '0; len_i_t0 = '0;
            if (abort_at > 0 && wr_addr.size() == abort_at && !(req_o && we_o)) begin
                rst_ni = 1'b0;
                #1;
                abort_req  = req_o;
                abort_busy = busy_o;
                break;
            end
            // Commands while busy must be ignored.
            if (noise && busy_o && $urandom_range(0, 1) == 1) begin
                start_i    = 1'b1;
                src_addr_i = AW'($urandom);
                dst_addr_i = AW'($urandom);
                len_i      = (AW + 1)'($urandom_range(1, 8));
            end
        end
        start_i = 1'b0;
        rd_seq_bad = 0;
        foreach (rd_addr[k]) if (rd_addr[k] !== AW'(src + AW'(k)) || rd_cyc[k] != 1 + 3 * k) rd_seq_bad++;
        wr_seq_bad = 0;
        foreach (wr_addr[k]) if (wr_addr[k] !== AW'(dst + AW'(k)) || wr_cyc[k] != 3 + 3 * k) wr_seq_bad++;
    endtask

    task automatic test_reset();
        start_i = 1'b0; start_i_t0 = '0; src_addr_i = '0; src_addr_i_t0 = '0;
        dst_addr_i = '0; dst_addr_i_t0 = '0; len_i = '0; len_i_t0 = '0;
        #1 rst_ni = 1'b0;
        #12;
        n_cmp++;
        if ({busy_o, done_o, req_o, we_o} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctrl: got %b expected 0000", {busy_o, done_o, req_o, we_o});
        end
        n_cmp++;
        if (addr_o !== '0 || wdata_o !== '0 || be_o !== '0) begin
            n_bad++; $display("FAIL reset_data: addr %h wdata %h be %h expected all 0", addr_o, wdata_o, be_o);
        end
        n_cmp++;
        if ({busy_o_t0, done_o_t0, req_o_t0, we_o_t0, addr_o_t0, wdata_o_t0, be_o_t0} !== '0) begin
            n_bad++; $display("FAIL reset_t0: taint outputs not all 0");
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        n_cmp++;
        if ({busy_o, done_o, req_o} !== 3'b0) begin
            n_bad++; $display("FAIL idle_after_reset: got %b expected 000", {busy_o, done_o, req_o});
        end
    endtask

    task automatic init_mem();
        for (int i = 0; i < NW; i++) bd_write(AW'(i), '0, '0);
    endtask

    task automatic test_basic();
        int n;
        for (int i = 0; i < 4; i++) bd_write(AW'(16 + i), DW'(32'hA0 + i), '0);
        run_copy(10'h010, 10'h040, 11'd4, 1'b0, '0, '0, '0, 0, 1'b0);
        model_copy(10'h010, 10'h040, 4, 1'b0);
        n_cmp++;
        if (done_cyc.size() != 1 || done_cyc[0] != 13) begin
            n_bad++; $display("FAIL basic_done: got %0d pulses (first at %0d) expected one at cycle 13",
                              done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        n_cmp++;
        if (rd_addr.size() != 4 || rd_seq_bad != 0) begin
            n_bad++; $display("FAIL basic_reads: got %0d reads, %0d misplaced, expected 4 / 0", rd_addr.size(), rd_seq_bad);
        end
        n_cmp++;
        if (wr_addr.size() != 4 || wr_seq_bad != 0) begin
            n_bad++; $display("FAIL basic_writes: got %0d writes, %0d misplaced, expected 4 / 0", wr_addr.size(), wr_seq_bad);
        end
        n = 0;
        for (int i = 0; i < 4; i++) if (mem[10'h040 + i] !== DW'(32'hA0 + i)) n++;
        n_cmp++;
        if (n != 0) begin
            n_bad++; $display("FAIL basic_dst_values: %0d of 4 words differ from 0xA0+i", n);
        end
        n_cmp++;
        if (mem_diff() != 0) begin
            n_bad++; $display("FAIL basic_mem: %0d words differ from model, expected 0", mem_diff());
        end
        n_cmp++;
        if (t0_nz != 0) begin
            n_bad++; $display("FAIL basic_t0: %0d cycles with nonzero taint outputs, expected 0", t0_nz);
        end
        n_cmp++;
        if (busy_bad != 0 || be_bad != 0) begin
            n_bad++; $display("FAIL basic_busy_be: busy errors %0d, be errors %0d, expected 0 / 0", busy_bad, be_bad);
        end
    endtask

    task automatic test_data_taint();
        int n;
        for (int i = 0; i < 4; i++) bd_write(AW'(16 + i), DW'(32'hA0 + i), (i == 2) ? DW'(8'hFF) : '0);
        run_copy(10'h010, 10'h040, 11'd4, 1'b0, '0, '0, '0, 0, 1'b0);
        model_copy(10'h010, 10'h040, 4, 1'b0);
        n_cmp++;
        if (memt[10'h042] !== DW'(8'hFF)) begin
            n_bad++; $display("FAIL data_taint_word: got %h expected ff", memt[10'h042]);
        end
        n = 0;
        for (int i = 0; i < 4; i++) if (i != 2 && memt[10'h040 + i] !== '0) n++;
        n_cmp++;
        if (n != 0) begin
            n_bad++; $display("FAIL data_taint_others: %0d clean words got taint, expected 0", n);
        end
        n = 0;
        foreach (rd_at[k]) if (rd_at[k] !== '0) n++;
        foreach (wr_at[k]) if (wr_at[k] !== '0) n++;
        n_cmp++;
        if (n != 0) begin
            n_bad++; $display("FAIL data_taint_addr_t0: %0d requests with tainted address, expected 0", n);
        end
        n_cmp++;
        if (mem_diff() != 0) begin
            n_bad++; $display("FAIL data_taint_mem: %0d words differ from model, expected 0", mem_diff());
        end
    endtask

    task automatic test_addr_taint();
        int n;
        run_copy(10'h010, 10'h040, 11'd4, 1'b0, 10'h001, '0, '0, 0, 1'b0);
        model_copy(10'h010, 10'h040, 4, 1'b1);
        n = 0;
        foreach (rd_at[k]) if (rd_at[k] !== '1) n++;
        n_cmp++;
        if (rd_at.size() != 4 || n != 0) begin
            n_bad++; $display("FAIL addr_taint_rd: %0d of %0d reads lacked all-ones addr taint, expected 0 of 4", n, rd_at.size());
        end
        n = 0;
        foreach (wr_at[k]) if (wr_at[k] !== '0) n++;
        n_cmp++;
        if (n != 0) begin
            n_bad++; $display("FAIL addr_taint_wr: %0d writes with addr taint, expected 0", n);
        end
        n = 0;
        for (int i = 0; i < 4; i++) if (memt[10'h040 + i] !== '1) n++;
        n_cmp++;
        if (n != 0) begin
            n_bad++; $display("FAIL addr_taint_dst: %0d dst words not fully tainted, expected 0", n);
        end
        n_cmp++;
        if (mem_diff() != 0) begin
            n_bad++; $display("FAIL addr_taint_mem: %0d words differ from model, expected 0", mem_diff());
        end
    endtask

    task automatic test_len_zero();
        run_copy(10'h100, 10'h200, 11'd0, 1'b0, '0, '0, '0, 0, 1'b0);
        n_cmp++;
        if (done_cyc.size() != 1 || done_cyc[0] != 1) begin
            n_bad++; $display("FAIL len0_done: got %0d pulses (first at %0d) expected one at cycle 1",
                              done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        n_cmp++;
        if (rd_addr.size() + wr_addr.size() != 0 || busy_bad != 0) begin
            n_bad++; $display("FAIL len0_noreq: got %0d requests, %0d busy errors, expected 0 / 0",
                              rd_addr.size() + wr_addr.size(), busy_bad);
        end
    endtask

    task automatic test_len_taint();
        for (int i = 0; i < 2; i++) bd_write(AW'(10'h120 + i), {$urandom, $urandom, $urandom, $urandom}, '0);
        run_copy(10'h120, 10'h220, 11'd2, 1'b0, '0, '0, 11'd1, 0, 1'b0);
        model_copy(10'h120, 10'h220, 2, 1'b1);
        n_cmp++;
        if (busy_cycles != 7 || ctrl_ones != busy_cycles) begin
            n_bad++; $display("FAIL len_taint_ctrl: %0d of %0d busy cycles had ctrl taints set, expected 7 of 7",
                              ctrl_ones, busy_cycles);
        end
        n_cmp++;
        if (done_cyc.size() != 1 || done_cyc[0] != 7 || mem_diff() != 0) begin
            n_bad++; $display("FAIL len_taint_result: %0d pulses, mem diff %0d, expected 1 pulse at cycle 7 / 0",
                              done_cyc.size(), mem_diff());
        end
    endtask

    task automatic test_wrap();
        int exp_rd[4] = '{1022, 1023, 0, 1};
        int n;
        for (int i = 0; i < 4; i++) bd_write(AW'(1022 + i), {$urandom, $urandom, $urandom, $urandom}, '0);
        run_copy(10'd1022, 10'h200, 11'd4, 1'b0, '0, '0, '0, 0, 1'b0);
        model_copy(10'd1022, 10'h200, 4, 1'b0);
        n = 0;
        foreach (rd_addr[k]) if (k < 4 && rd_addr[k] !== AW'(exp_rd[k])) n++;
        n_cmp++;
        if (rd_addr.size() != 4 || n != 0) begin
            n_bad++; $display("FAIL wrap_reads: %0d reads, %0d wrong addresses, expected 4 / 0", rd_addr.size(), n);
        end
        n_cmp++;
        if (mem_diff() != 0) begin
            n_bad++; $display("FAIL wrap_mem: %0d words differ from model, expected 0", mem_diff());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) bd_write(AW'(10'h080 + i), {$urandom, $urandom, $urandom, $urandom}, '0);
        for (int i = 0; i < 4; i++) bd_write(AW'(10'h300 + i), {4{32'h5555_5555}}, '0);
        run_copy(10'h080, 10'h300, 11'd4, 1'b0, '0, '0, '0, 2, 1'b0);
        model_copy(10'h080, 10'h300, 2, 1'b0);
        n_cmp++;
        if (abort_req !== 1'b0 || abort_busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_outputs: req %b busy %b expected 0 0", abort_req, abort_busy);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        n_cmp++;
        if (wr_addr.size() != 2 || mem_diff() != 0) begin
            n_bad++; $display("FAIL reset_mid_partial: %0d writes, mem diff %0d, expected 2 / 0", wr_addr.size(), mem_diff());
        end
        run_copy(10'h080, 10'h310, 11'd3, 1'b0, '0, '0, '0, 0, 1'b0);
        model_copy(10'h080, 10'h310, 3, 1'b0);
        n_cmp++;
        if (done_cyc.size() != 1 || done_cyc[0] != 10 || mem_diff() != 0) begin
            n_bad++; $display("FAIL reset_mid_restart: %0d pulses, mem diff %0d, expected 1 pulse at cycle 10 / 0",
                              done_cyc.size(), mem_diff());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [AW-1:0] src, dst, st;
            logic [AW:0]   len;
            int            exp_done;
            src = AW'($urandom);
            dst = AW'($urandom);
            len = (AW + 1)'($urandom_range(1, 6));
            st  = ($urandom_range(0, 3) == 0) ? AW'(1 << $urandom_range(0, AW - 1)) : '0;
            exp_done = int'(len) * 3 + 1;
            for (int k = 0; k < int'(len); k++)
                bd_write(src + AW'(k), {$urandom, $urandom, $urandom, $urandom},
                         ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0);
            run_copy(src, dst, len, 1'b0, st, '0, '0, 0, 1'b1);
            model_copy(src, dst, int'(len), st != '0);
            n_cmp++;
            if (done_cyc.size() != 1 || done_cyc[0] != exp_done || busy_bad != 0) begin
                n_bad++; $display("FAIL rand%0d_done: %0d pulses (first at %0d), busy errors %0d, expected one at %0d / 0",
                                  it, done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, busy_bad, exp_done);
            end
            n_cmp++;
            if (rd_addr.size() != int'(len) || rd_seq_bad != 0) begin
                n_bad++; $display("FAIL rand%0d_reads: %0d reads, %0d misplaced, expected %0d / 0",
                                  it, rd_addr.size(), rd_seq_bad, len);
            end
            n_cmp++;
            if (wr_addr.size() != int'(len) || wr_seq_bad != 0) begin
                n_bad++; $display("FAIL rand%0d_writes: %0d writes, %0d misplaced, expected %0d / 0",
                                  it, wr_addr.size(), wr_seq_bad, len);
            end
            n_cmp++;
            if (mem_diff() != 0) begin
                n_bad++; $display("FAIL rand%0d_mem: %0d words differ from model, expected 0", it, mem_diff());
            end
        end
    endtask

    initial begin
        test_reset();
        init_mem();
        test_basic();
        test_data_taint();
        test_addr_taint();
        test_len_zero();
        test_len_taint();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
